// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM state
// encoding, word width, the value returned by out-of-range loads, and the
// word-index range check used by the access path.
package mem_pkg;

  localparam int WORD_W = 32;
  localparam logic [31:0] MEM_ERR_DATA = 32'h0;

  // Wait-state counter width; LATENCY is limited to 0..15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_RESP
  } mem_state_t;

  // A word address is serviceable only when it falls inside the array; upper
  // address bits are not allowed to alias back onto low words.
  function automatic logic word_in_range(input logic [29:0] waddr,
                                         input int unsigned depth);
    return ({2'b00, waddr} < depth);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the core datapath (master) and the data-memory
// responder (slave). The core holds MemReq until it sees MemReady.
interface dmem_responder_if;
  import mem_pkg::*;

  logic              MemReq;
  logic              MemWrite;
  logic [WORD_W-1:0] Addr;
  logic [WORD_W-1:0] WriteData;
  logic [WORD_W-1:0] ReadData;
  logic              MemReady;
  logic              MemErr;

  modport master (
    output MemReq, MemWrite, Addr, WriteData,
    input  ReadData, MemReady, MemErr
  );

  modport slave (
    input  MemReq, MemWrite, Addr, WriteData,
    output ReadData, MemReady, MemErr
  );

endinterface

// File: rtl/dmem_responder_array.sv
// Word storage for the data-memory responder: DEPTH x 32 bits, synchronous
// write, combinational read on the same address port.
module dmem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WORD_W-1:0]        wd,
  output logic [WORD_W-1:0]        rd
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Commit a store on the clock edge when the responder enables it.
  // NOTE: the storage has no reset; clearing a RAM would need a per-word
  // sequencer and the contents are defined only by what software writes.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wd;
    end
  end

  assign rd = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: captures a load/store request from the core, waits
// LATENCY cycles, performs the word access and returns a one-cycle MemReady
// pulse (with MemErr for out-of-range words). ReadData holds the last load.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mem_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt;

  // Captured request; only the word part of the address is kept.
  logic              cap_write;
  logic [29:0]       cap_waddr;
  logic [WORD_W-1:0] cap_wdata;

  // Access path as seen on the edge that performs the access.
  logic              acc_fire;
  logic              acc_write;
  logic [29:0]       acc_waddr;
  logic [WORD_W-1:0] acc_wdata;
  logic              acc_ok;
  logic [AW-1:0]     acc_idx;
  logic              arr_we;
  logic [WORD_W-1:0] arr_rd;

  logic              ready_q;
  logic              err_q;
  logic [WORD_W-1:0] rdata_q;

  // Byte offset within a word carries no meaning for word accesses.
  logic              addr_lo_unused;
  assign addr_lo_unused = ^bus.Addr[1:0];

  // Next state and access source: with zero latency the access happens on
  // the capture edge and must use the live inputs; otherwise the copies.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would infer a latch.
    state_nxt = state;
    acc_fire  = 1'b0;
    acc_write = cap_write;
    acc_waddr = cap_waddr;
    acc_wdata = cap_wdata;
    case (state)
      MEM_IDLE: begin
        if (bus.MemReq) begin
          if (LATENCY == 0) begin
            acc_fire  = 1'b1;
            acc_write = bus.MemWrite;
            acc_waddr = bus.Addr[31:2];
            acc_wdata = bus.WriteData;
            state_nxt = MEM_RESP;
          end else begin
            state_nxt = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        if (cnt == CNT_ONE) begin
          acc_fire  = 1'b1;
          state_nxt = MEM_RESP;
        end
      end
      MEM_RESP: state_nxt = MEM_IDLE;
      default:  state_nxt = MEM_IDLE;
    endcase
  end

  // Range check, array index and write enable for the pending access. The
  // reset term keeps a request presented during reset out of the array.
  always_comb begin
    acc_ok  = word_in_range(acc_waddr, DEPTH);
    acc_idx = acc_waddr[AW-1:0];
    arr_we  = acc_fire && acc_write && acc_ok && !reset;
  end

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .addr (acc_idx),
    .wd   (acc_wdata),
    .rd   (arr_rd)
  );

  // FSM state, wait counter and request capture.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= MEM_IDLE;
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_waddr <= '0;
      cap_wdata <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        MEM_IDLE: begin
          if (bus.MemReq) begin
            cap_write <= bus.MemWrite;
            cap_waddr <= bus.Addr[31:2];
            cap_wdata <= bus.WriteData;
            cnt       <= LAT_INIT;
          end
        end
        MEM_WAIT: cnt <= cnt - CNT_ONE;
        default:  ;
      endcase
    end
  end

  // Completion pulse, error flag and held load data, registered on the edge
  // that enters RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= acc_fire;
      err_q   <= acc_fire && !acc_ok;
      if (acc_fire && !acc_write) begin
        rdata_q <= acc_ok ? arr_rd : MEM_ERR_DATA;
      end
    end
  end

  assign bus.MemReady = ready_q;
  assign bus.MemErr   = err_q;
  assign bus.ReadData = rdata_q;

  // MemReady is a single-cycle pulse and MemErr never appears without it.
  ready_pulse_a : assert property (@(posedge clk) disable iff (reset)
                                   ready_q |=> !ready_q);
  err_with_ready_a : assert property (@(posedge clk) disable iff (reset)
                                      err_q |-> ready_q);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with LATENCY=2 and one with
// LATENCY=0, both DEPTH=64, sharing clock and reset.
module tb_dmem_responder;
  import mem_pkg::*;

  localparam bit L2 = 1'b0;  // LATENCY=2 instance
  localparam bit L0 = 1'b1;  // LATENCY=0 instance

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dmem_responder_if bus2 ();
  dmem_responder_if bus0 ();

  dmem_responder #(.DEPTH(64), .LATENCY(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  dmem_responder #(.DEPTH(64), .LATENCY(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic rq, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd);
    if (sel) begin
      bus0.MemReq = rq; bus0.MemWrite = wr; bus0.Addr = a; bus0.WriteData = wd;
    end else begin
      bus2.MemReq = rq; bus2.MemWrite = wr; bus2.Addr = a; bus2.WriteData = wd;
    end
  endtask

  function automatic logic get_ready(input bit sel);
    return sel ? bus0.MemReady : bus2.MemReady;
  endfunction

  function automatic logic get_err(input bit sel);
    return sel ? bus0.MemErr : bus2.MemErr;
  endfunction

  function automatic logic [31:0] get_rdata(input bit sel);
    return sel ? bus0.ReadData : bus2.ReadData;
  endfunction

  // One request: present in cycle 0, report the cycle MemReady is seen in
  // (-1 on timeout). With tog set, the inputs are changed in cycle 1.
  task automatic req(input bit sel, input bit wr, input logic [31:0] a,
                     input logic [31:0] wd, input bit tog,
                     input logic [31:0] ta, input logic [31:0] twd,
                     output int lat, output logic [31:0] rd, output logic err);
    lat = -1;
    rd  = '0;
    err = 1'b0;
    @(negedge clk);
    drive(sel, 1'b1, wr, a, wd);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (tog && n == 1) drive(sel, 1'b1, ~wr, ta, twd);
      if (get_ready(sel)) begin
        lat = n;
        rd  = get_rdata(sel);
        err = get_err(sel);
        break;
      end
    end
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic xfer_chk(input string tag, input bit sel, input bit wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input bit tog, input logic [31:0] ta,
                          input logic [31:0] twd, input int elat,
                          input logic [31:0] erd, input logic eerr);
    int          lat;
    logic [31:0] rd;
    logic        err;
    req(sel, wr, a, wd, tog, ta, twd, lat, rd, err);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_rdata"}, rd, erd);
    check({tag, "_err"}, {31'b0, err}, {31'b0, eerr});
  endtask

  task automatic op(input string tag, input bit sel, input bit wr,
                    input logic [31:0] a, input logic [31:0] wd, input int elat,
                    input logic [31:0] erd, input logic eerr);
    xfer_chk(tag, sel, wr, a, wd, 1'b0, '0, '0, elat, erd, eerr);
  endtask

  // Hold MemReq high for 8 cycles and record MemReady in cycles 1..8.
  task automatic stream(input bit sel, input logic [31:0] a,
                        output logic [7:0] mask);
    mask = '0;
    @(negedge clk);
    drive(sel, 1'b1, 1'b0, a, '0);
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
      mask[n-1] = get_ready(sel);
    end
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    int          lat;
    int          pulses;
    logic [7:0]  mask;

    reset = 1'b1;
    drive(L2, 1'b0, 1'b0, '0, '0);
    drive(L0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    check("rst_ready2", {31'b0, bus2.MemReady}, 32'h0);
    check("rst_err2",   {31'b0, bus2.MemErr},   32'h0);
    check("rst_rdata2", bus2.ReadData,          32'h0);
    check("rst_ready0", {31'b0, bus0.MemReady}, 32'h0);
    check("rst_rdata0", bus0.ReadData,          32'h0);
    reset = 1'b0;

    // Reset in the middle of a store's wait states.
    op("t1_pre", L2, 1'b1, 32'h10, 32'h5A5A_5A5A, 3, 32'h0, 1'b0);
    @(negedge clk);
    drive(L2, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("t1_wait_ready", {31'b0, bus2.MemReady}, 32'h0);
    reset = 1'b1;
    drive(L2, 1'b0, 1'b0, '0, '0);
    #1;
    check("t1_rst_ready", {31'b0, bus2.MemReady}, 32'h0);
    check("t1_rst_err",   {31'b0, bus2.MemErr},   32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    op("t1_load", L2, 1'b0, 32'h10, '0, 3, 32'h5A5A_5A5A, 1'b0);

    // LATENCY=2 store then load; ReadData holds across the store.
    op("t2_store", L2, 1'b1, 32'h20, 32'hCAFE_F00D, 3, 32'h5A5A_5A5A, 1'b0);
    @(posedge clk);
    #1;
    check("t2_one_cycle", {31'b0, bus2.MemReady}, 32'h0);
    op("t2_load", L2, 1'b0, 32'h20, '0, 3, 32'hCAFE_F00D, 1'b0);

    // LATENCY=0 store/load and back-to-back throughput.
    op("t3_store", L0, 1'b1, 32'h04, 32'h1234_5678, 1, 32'h0, 1'b0);
    op("t3_load",  L0, 1'b0, 32'h04, '0, 1, 32'h1234_5678, 1'b0);
    stream(L0, 32'h04, mask);
    check("t3_b2b_mask", {24'b0, mask}, 32'h55);
    stream(L2, 32'h20, mask);
    check("t3_b2b_mask_l2", {24'b0, mask}, 32'h44);

    // Out-of-range word: error, zero data, no aliasing onto word 0.
    op("t4_w0",    L2, 1'b1, 32'h00, 32'h0BAD_F00D, 3, 32'hCAFE_F00D, 1'b0);
    op("t4_w63",   L2, 1'b1, 32'hFC, 32'hFEED_FACE, 3, 32'hCAFE_F00D, 1'b0);
    op("t4_ld_oor", L2, 1'b0, 32'h100, '0, 3, 32'h0, 1'b1);
    op("t4_st_oor", L2, 1'b1, 32'h100, 32'h7777_7777, 3, 32'h0, 1'b1);
    op("t4_ld_w0", L2, 1'b0, 32'h00, '0, 3, 32'h0BAD_F00D, 1'b0);
    op("t4_ld_w63", L2, 1'b0, 32'hFC, '0, 3, 32'hFEED_FACE, 1'b0);
    op("t4_ld_hi", L2, 1'b0, 32'h8000_0000, '0, 3, 32'h0, 1'b1);

    // Inputs changed during WAIT are ignored; byte offset is ignored.
    op("t5_st08", L2, 1'b1, 32'h08, 32'h1111_1111, 3, 32'h0, 1'b0);
    op("t5_st0c", L2, 1'b1, 32'h0C, 32'h2222_2222, 3, 32'h0, 1'b0);
    xfer_chk("t5_tog_ld", L2, 1'b0, 32'h08, '0, 1'b1, 32'h0C, 32'hBBBB_BBBB,
             3, 32'h1111_1111, 1'b0);
    xfer_chk("t5_tog_st", L2, 1'b1, 32'h08, 32'hAAAA_AAAA, 1'b1, 32'h0C,
             32'h3333_3333, 3, 32'h1111_1111, 1'b0);
    op("t5_ld0c", L2, 1'b0, 32'h0C, '0, 3, 32'h2222_2222, 1'b0);
    op("t5_ld0b", L2, 1'b0, 32'h0B, '0, 3, 32'hAAAA_AAAA, 1'b0);

    // MemReq held through RESP yields exactly one access.
    lat = -1;
    @(negedge clk);
    drive(L2, 1'b1, 1'b1, 32'h30, 32'h4444_4444);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (bus2.MemReady) begin
        lat = n;
        break;
      end
    end
    check("t6_lat", 32'(lat), 32'd3);
    @(posedge clk);
    #1;
    drive(L2, 1'b0, 1'b0, '0, '0);
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      if (bus2.MemReady) pulses++;
    end
    check("t6_extra_pulses", 32'(pulses), 32'd0);
    op("t6_ld30", L2, 1'b0, 32'h30, '0, 3, 32'h4444_4444, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
